fp_add_align: RTL and testbench

- Upstream stage of the single-precision FP adder mantissa datapath; feeds the 24-bit two's-complement stage and the mantissa adder.
- Accepts two IEEE-754 binary32 operands and unpacks them.
- Orders the operands by magnitude and right-shifts the smaller mantissa by the exponent difference, keeping guard/round/sticky.
- Emits aligned 24-bit mantissas, the result exponent/sign and the complement request through a 2-stage valid/ready pipeline.

---
 rtl/fp_add_align_if.sv | 26 ++
 rtl/fp_add_align.sv | 109 ++++++++++
 tb/tb_fp_add_align.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fp_add_align_if.sv
// fp_add_align_if: operand-in / aligned-mantissa-out valid/ready bundle for the FP adder align stage.
interface fp_add_align_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] big_mant;
    logic [23:0] small_mant;
    logic [2:0]  grs;
    logic [7:0]  exp_out;
    logic        sign_out;
    logic        complement;
    logic        special;

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, big_mant, small_mant, grs, exp_out, sign_out, complement, special
    );

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, big_mant, small_mant, grs, exp_out, sign_out, complement, special
    );
endinterface

// File: rtl/fp_add_align.sv
// fp_add_align: unpack two binary32 operands, order by magnitude and right-align the smaller mantissa with GRS.
module fp_add_align #(
    parameter int MAX_SHIFT = 27
) (
    input  logic          clk,
    input  logic          rst,
    fp_add_align_if.slave bus
);
    logic [7:0]  ea, eb, ea_eff, eb_eff;
    logic [23:0] ma, mb;
    logic        a_big, s1_adv, s2_adv;

    logic        s1_valid_q;
    logic [23:0] s1_big_q, s1_small_q, s1_big_d, s1_small_d;
    logic [7:0]  s1_exp_q, s1_diff_q, s1_exp_d, s1_diff_d;
    logic        s1_sign_q, s1_comp_q, s1_spec_q, s1_sign_d, s1_comp_d, s1_spec_d;

    logic        s2_valid_q;
    logic [23:0] s2_big_q, s2_small_q, s2_small_d;
    logic [2:0]  s2_grs_q, s2_grs_d;
    logic [7:0]  s2_exp_q;
    logic        s2_sign_q, s2_comp_q, s2_spec_q;

    logic [26:0] wide, shifted;
    logic        full, lost;

    assign ea     = bus.op_a[30:23];
    assign eb     = bus.op_b[30:23];
    // Denormals sit at exponent 1 with no hidden bit so they align against normals correctly.
    assign ea_eff = (ea == 8'd0) ? 8'd1 : ea;
    assign eb_eff = (eb == 8'd0) ? 8'd1 : eb;
    assign ma     = {ea != 8'd0, bus.op_a[22:0]};
    assign mb     = {eb != 8'd0, bus.op_b[22:0]};
    assign a_big  = {ea_eff, ma} >= {eb_eff, mb};

    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign bus.in_ready = s1_adv;

    always_comb begin
        s1_big_d   = a_big ? ma : mb;
        s1_small_d = a_big ? mb : ma;
        s1_exp_d   = a_big ? ea_eff : eb_eff;
        s1_diff_d  = a_big ? ea_eff - eb_eff : eb_eff - ea_eff;
        s1_sign_d  = a_big ? bus.op_a[31] : bus.op_b[31];
        s1_comp_d  = bus.op_a[31] ^ bus.op_b[31];
        s1_spec_d  = (ea == 8'hFF) || (eb == 8'hFF);
    end

    always_comb begin
        wide       = {s1_small_q, 3'b000};
        full       = s1_diff_q >= 8'(MAX_SHIFT);
        shifted    = full ? 27'd0 : wide >> s1_diff_q;
        lost       = full ? (s1_small_q != 24'd0) : |(wide & ~(27'h7FFFFFF << s1_diff_q));
        s2_small_d = shifted[26:3];
        s2_grs_d   = {shifted[2:1], shifted[0] | lost};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_big_q   <= '0;
            s1_small_q <= '0;
            s1_exp_q   <= '0;
            s1_diff_q  <= '0;
            s1_sign_q  <= 1'b0;
            s1_comp_q  <= 1'b0;
            s1_spec_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_big_q   <= '0;
            s2_small_q <= '0;
            s2_grs_q   <= '0;
            s2_exp_q   <= '0;
            s2_sign_q  <= 1'b0;
            s2_comp_q  <= 1'b0;
            s2_spec_q  <= 1'b0;
        end else begin
            if (s1_adv) s1_valid_q <= bus.in_valid;
            if (s1_adv && bus.in_valid) begin
                s1_big_q   <= s1_big_d;
                s1_small_q <= s1_small_d;
                s1_exp_q   <= s1_exp_d;
                s1_diff_q  <= s1_diff_d;
                s1_sign_q  <= s1_sign_d;
                s1_comp_q  <= s1_comp_d;
                s1_spec_q  <= s1_spec_d;
            end
            if (s2_adv) s2_valid_q <= s1_valid_q;
            if (s2_adv && s1_valid_q) begin
                s2_big_q   <= s1_big_q;
                s2_small_q <= s2_small_d;
                s2_grs_q   <= s2_grs_d;
                s2_exp_q   <= s1_exp_q;
                s2_sign_q  <= s1_sign_q;
                s2_comp_q  <= s1_comp_q;
                s2_spec_q  <= s1_spec_q;
            end
        end
    end

    assign bus.out_valid  = s2_valid_q;
    assign bus.big_mant   = s2_big_q;
    assign bus.small_mant = s2_small_q;
    assign bus.grs        = s2_grs_q;
    assign bus.exp_out    = s2_exp_q;
    assign bus.sign_out   = s2_sign_q;
    assign bus.complement = s2_comp_q;
    assign bus.special    = s2_spec_q;
endmodule

// File: tb/tb_fp_add_align.sv
// tb_fp_add_align: directed vectors with hand-computed aligned results for fp_add_align.
module tb_fp_add_align;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    fp_add_align_if bus ();
    fp_add_align #(.MAX_SHIFT(27)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic [63:0] pe [4];
    logic [63:0] held_val;
    int          sent, got;
    bit          held, saw_stall, accept;

    function automatic logic [63:0] pk(logic [23:0] b, logic [23:0] s, logic [2:0] g, logic [7:0] e,
                                       logic sg, logic c, logic sp);
        return {2'b00, b, s, g, e, sg, c, sp};
    endfunction

    function automatic logic [63:0] obs();
        return pk(bus.big_mant, bus.small_mant, bus.grs, bus.exp_out, bus.sign_out, bus.complement, bus.special);
    endfunction

    task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(string tag, logic [31:0] a, logic [31:0] b, logic [63:0] e);
        bus.op_a = a;
        bus.op_b = b;
        bus.in_valid = 1'b1;
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_valid_early"}, 64'(bus.out_valid), 64'd0);
        tick();
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk(tag, obs(), e);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_data", obs(), 64'd0);

        single("one_one", 32'h3F800000, 32'h3F800000, pk(24'h800000, 24'h800000, 3'b000, 8'd127, 1'b0, 1'b0, 1'b0));
        single("swap",    32'h3F000000, 32'hC0000000, pk(24'h800000, 24'h200000, 3'b000, 8'd128, 1'b1, 1'b1, 1'b0));
        single("diff30",  32'h3F800000, 32'h30800000, pk(24'h800000, 24'h000000, 3'b001, 8'd127, 1'b0, 1'b0, 1'b0));
        single("diff2",   32'h40000000, 32'h3F400001, pk(24'h800000, 24'h300000, 3'b010, 8'd128, 1'b0, 1'b0, 1'b0));
        single("diff25",  32'h3F800000, 32'h33000000, pk(24'h800000, 24'h000000, 3'b010, 8'd127, 1'b0, 1'b0, 1'b0));
        single("diff24s", 32'h3F800000, 32'h33C00001, pk(24'h800000, 24'h000000, 3'b111, 8'd127, 1'b0, 1'b0, 1'b0));
        single("inf",     32'h7F800000, 32'h3F800000, pk(24'h800000, 24'h000000, 3'b001, 8'd255, 1'b0, 1'b0, 1'b1));
        single("zeros",   32'h80000000, 32'h00000000, pk(24'h000000, 24'h000000, 3'b000, 8'd1,   1'b1, 1'b1, 1'b0));
        single("denorm",  32'h00000001, 32'h00800000, pk(24'h800000, 24'h000001, 3'b000, 8'd1,   1'b0, 1'b0, 1'b0));

        pa[0] = 32'h3F800000; pb[0] = 32'h3F800000; pe[0] = pk(24'h800000, 24'h800000, 3'b000, 8'd127, 1'b0, 1'b0, 1'b0);
        pa[1] = 32'h40000000; pb[1] = 32'h3F800000; pe[1] = pk(24'h800000, 24'h400000, 3'b000, 8'd128, 1'b0, 1'b0, 1'b0);
        pa[2] = 32'hBF800000; pb[2] = 32'h40400000; pe[2] = pk(24'hC00000, 24'h400000, 3'b000, 8'd128, 1'b0, 1'b1, 1'b0);
        pa[3] = 32'h3F400001; pb[3] = 32'h40000000; pe[3] = pk(24'h800000, 24'h300000, 3'b010, 8'd128, 1'b0, 1'b0, 1'b0);
        sent = 0;
        got = 0;
        held = 1'b0;
        saw_stall = 1'b0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            bus.in_valid = (sent < 4);
            bus.op_a = pa[(sent < 4) ? sent : 0];
            bus.op_b = pb[(sent < 4) ? sent : 0];
            bus.out_ready = !(cyc >= 3 && cyc <= 5);
            #7;
            if (held) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_data", obs(), held_val);
            end
            if (!bus.in_ready) saw_stall = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("b2b_%0d", got), obs(), pe[got]);
                got++;
            end
            held = bus.out_valid && !bus.out_ready;
            held_val = obs();
            accept = bus.in_valid && bus.in_ready;
            tick();
            if (accept) sent++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("b2b_count", 64'(got), 64'd4);
        chk("b2b_stall", 64'(saw_stall), 64'd1);
        repeat (2) tick();
        chk("b2b_no_extra", 64'(bus.out_valid), 64'd0);

        bus.op_a = 32'h40000000;
        bus.op_b = 32'h3F800000;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_data", obs(), 64'd0);
        rst = 1'b0;
        tick();
        chk("midrst_valid_after", 64'(bus.out_valid), 64'd0);
        single("post_rst", 32'h3F800000, 32'h3F800000, pk(24'h800000, 24'h800000, 3'b000, 8'd127, 1'b0, 1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
